// File: rtl/fifo_pkg.sv
// Shared FIFO constants for the read- and write-side pointer blocks.
package fifo_pkg;

  localparam int FIFO_ADD_SIZE      = 4;
  localparam int FIFO_AEMPTY_THRESH = 2;

endpackage

// File: rtl/rptr_aempty_if.sv
// Read-side pointer bus. Optional underflow error port when
// RPTR_UNDERFLOW_ERR_EN is defined.
interface rptr_aempty_if
  import fifo_pkg::*;
#(
  parameter int ADD_SIZE = FIFO_ADD_SIZE
) ();

  logic                rinc;
  logic [ADD_SIZE:0]   rq2_wptr;
  logic [ADD_SIZE-1:0] raddr;
  logic [ADD_SIZE:0]   rptr;
  logic                rempty;
  logic                raempty;
  logic [ADD_SIZE:0]   rlevel;
`ifdef RPTR_UNDERFLOW_ERR_EN
  logic                rerr;
  logic                rerr_clr;

  modport master (
    output rinc, rq2_wptr, rerr_clr,
    input  raddr, rptr, rempty, raempty, rlevel, rerr
  );

  modport slave (
    input  rinc, rq2_wptr, rerr_clr,
    output raddr, rptr, rempty, raempty, rlevel, rerr
  );
`else
  modport master (
    output rinc, rq2_wptr,
    input  raddr, rptr, rempty, raempty, rlevel
  );

  modport slave (
    input  rinc, rq2_wptr,
    output raddr, rptr, rempty, raempty, rlevel
  );
`endif

endinterface

// File: rtl/gray2bin.sv
// Purely combinational Gray-to-binary converter, shared by both pointer blocks.
module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at and above its position.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/rptr_aempty.sv
// Async FIFO read pointer with empty, almost-empty and fill-level flags.
// Optional sticky underflow flag when RPTR_UNDERFLOW_ERR_EN is defined.
// The level is computed against the synchronised (lagging) write pointer,
// so it can only under-report the data actually present.
module rptr_aempty
  import fifo_pkg::*;
#(
  parameter int ADD_SIZE      = FIFO_ADD_SIZE,
  parameter int AEMPTY_THRESH = FIFO_AEMPTY_THRESH
) (
  input logic          rclk,
  input logic          rrst_n,
  rptr_aempty_if.slave bus
);

  localparam int                PW     = ADD_SIZE + 1;
  localparam logic [ADD_SIZE:0] THRESH = PW'(AEMPTY_THRESH);

  logic [ADD_SIZE:0] rbin;
  logic [ADD_SIZE:0] rbin_next;
  logic [ADD_SIZE:0] rgray_next;
  logic [ADD_SIZE:0] wbin;
  logic [ADD_SIZE:0] fill_next;
  logic [ADD_SIZE:0] rptr_q;
  logic [ADD_SIZE:0] rlevel_q;
  logic              rempty_q;
  logic              raempty_q;
  logic              accept;

  assign accept     = bus.rinc & ~rempty_q;
  assign rbin_next  = rbin + {{ADD_SIZE{1'b0}}, accept};
  assign rgray_next = rbin_next ^ (rbin_next >> 1);
  assign fill_next  = wbin - rbin_next;

  gray2bin #(.WIDTH(PW)) u_gray2bin (
    .gray (bus.rq2_wptr),
    .bin  (wbin)
  );

  // Pointer and flag registers; flags look ahead at the post-pop pointer so
  // popping the last word raises rempty on the same edge.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rptr_q    <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      rlevel_q  <= '0;
    end else begin
      rbin      <= rbin_next;
      rptr_q    <= rgray_next;
      rempty_q  <= (rgray_next == bus.rq2_wptr);
      raempty_q <= (fill_next <= THRESH);
      rlevel_q  <= fill_next;
    end
  end

  assign bus.raddr   = rbin[ADD_SIZE-1:0];
  assign bus.rptr    = rptr_q;
  assign bus.rempty  = rempty_q;
  assign bus.raempty = raempty_q;
  assign bus.rlevel  = rlevel_q;

`ifdef RPTR_UNDERFLOW_ERR_EN
  logic rerr_q;

  // Sticky underflow flag; a new underflow beats a simultaneous clear.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rerr_q <= 1'b0;
    end else if (bus.rinc && rempty_q) begin
      rerr_q <= 1'b1;
    end else if (bus.rerr_clr) begin
      rerr_q <= 1'b0;
    end
  end

  assign bus.rerr = rerr_q;
`endif

endmodule

// File: tb/tb_rptr_aempty.sv
// Directed bench for rptr_aempty (ADD_SIZE=4, AEMPTY_THRESH=2).
// Exercises the underflow flag too when RPTR_UNDERFLOW_ERR_EN is defined.
module tb_rptr_aempty;
  import fifo_pkg::*;

  logic rclk;
  logic rrst_n;
  int   checks;
  int   errors;

  rptr_aempty_if #(.ADD_SIZE(4)) bus ();

  rptr_aempty #(.ADD_SIZE(4), .AEMPTY_THRESH(2)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rptr"},    32'(bus.rptr),    0);
    chk({tag, "_raddr"},   32'(bus.raddr),   0);
    chk({tag, "_rempty"},  32'(bus.rempty),  1);
    chk({tag, "_raempty"}, 32'(bus.raempty), 1);
    chk({tag, "_rlevel"},  32'(bus.rlevel),  0);
  endtask

  logic [4:0] wb;
  logic [4:0] exp_rbin;
  logic [4:0] exp_level;
  logic       exp_rempty;
  logic       acc;
  logic [4:0] prev_rptr;
  logic [3:0] prev_raddr;
  int         pops;
  int         raddr_wraps;
  int         rptr_wraps;

  initial begin
    checks = 0;
    errors = 0;
    rrst_n = 1'b0;
    bus.rinc = 1'b1;
    bus.rq2_wptr = 5'b00011;
`ifdef RPTR_UNDERFLOW_ERR_EN
    bus.rerr_clr = 1'b0;
`endif

    // Reset with rinc high and a non-zero write pointer
    tick();
    tick();
    chk_reset_vals("reset");
`ifdef RPTR_UNDERFLOW_ERR_EN
    chk("reset_rerr", 32'(bus.rerr), 0);
`endif

    // Fill level: five words visible, no reads
    rrst_n = 1'b1;
    bus.rinc = 1'b0;
    bus.rq2_wptr = 5'b00111;
    tick();
    chk("fill_rlevel",  32'(bus.rlevel),  5);
    chk("fill_rempty",  32'(bus.rempty),  0);
    chk("fill_raempty", 32'(bus.raempty), 0);

    bus.rinc = 1'b1;
    tick();
    chk("pop1_rlevel",  32'(bus.rlevel),  4);
    chk("pop1_raempty", 32'(bus.raempty), 0);
    tick();
    chk("pop2_rlevel",  32'(bus.rlevel),  3);
    chk("pop2_raempty", 32'(bus.raempty), 0);
    tick();
    chk("pop3_rlevel",  32'(bus.rlevel),  2);
    chk("pop3_raempty", 32'(bus.raempty), 1);
    chk("pop3_rempty",  32'(bus.rempty),  0);
    chk("pop3_raddr",   32'(bus.raddr),   3);
    chk("pop3_rptr",    32'(bus.rptr),    32'b00010);
    tick();
    chk("pop4_rlevel",  32'(bus.rlevel),  1);
    chk("pop4_rempty",  32'(bus.rempty),  0);
    tick();
    chk("pop5_rempty",  32'(bus.rempty),  1);
    chk("pop5_rlevel",  32'(bus.rlevel),  0);
    chk("pop5_raempty", 32'(bus.raempty), 1);
    chk("pop5_raddr",   32'(bus.raddr),   5);
    chk("pop5_rptr",    32'(bus.rptr),    32'b00111);

    // Pops past empty are ignored
    tick();
    chk("past_empty_raddr", 32'(bus.raddr), 5);

    // Underflow from a fresh reset
    bus.rinc = 1'b0;
    rrst_n = 1'b0;
    tick();
    rrst_n = 1'b1;
    bus.rq2_wptr = 5'b00000;
    bus.rinc = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("under_raddr",  32'(bus.raddr),  0);
      chk("under_rptr",   32'(bus.rptr),   0);
      chk("under_rempty", 32'(bus.rempty), 1);
`ifdef RPTR_UNDERFLOW_ERR_EN
      chk("under_rerr",   32'(bus.rerr),   1);
`endif
    end
    bus.rinc = 1'b0;
`ifdef RPTR_UNDERFLOW_ERR_EN
    bus.rerr_clr = 1'b1;
    tick();
    chk("rerr_clear", 32'(bus.rerr), 0);
    bus.rinc = 1'b1;
    tick();
    chk("rerr_set_wins", 32'(bus.rerr), 1);
    bus.rinc = 1'b0;
    tick();
    chk("rerr_clear2", 32'(bus.rerr), 0);
    bus.rerr_clr = 1'b0;
    tick();
    chk("rerr_hold0", 32'(bus.rerr), 0);
`endif

    // Wrap: write pointer advances each cycle, reader pops continuously
    wb = 5'd0;
    exp_rbin = 5'd0;
    exp_rempty = 1'b1;
    prev_rptr = 5'd0;
    prev_raddr = 4'd0;
    pops = 0;
    raddr_wraps = 0;
    rptr_wraps = 0;
    for (int c = 0; c < 100 && pops < 40; c++) begin
      wb = wb + 5'd1;
      bus.rq2_wptr = g(wb);
      bus.rinc = 1'b1;
      acc = !exp_rempty;
      exp_rbin = exp_rbin + {4'd0, acc};
      pops += int'(acc);
      exp_rempty = (exp_rbin == wb);
      exp_level = wb - exp_rbin;
      tick();
      chk("wrap_rptr",   32'(bus.rptr),   32'(g(exp_rbin)));
      chk("wrap_raddr",  32'(bus.raddr),  32'(exp_rbin[3:0]));
      chk("wrap_rlevel", 32'(bus.rlevel), 32'(exp_level));
      chk("wrap_rempty", 32'(bus.rempty), 32'(exp_rempty));
      chk("wrap_gray_step", 32'($countones(bus.rptr ^ prev_rptr)), acc ? 1 : 0);
      if (prev_raddr == 4'd15 && bus.raddr == 4'd0) raddr_wraps++;
      if (prev_rptr == 5'b10000 && bus.rptr == 5'b00000) rptr_wraps++;
      prev_rptr = bus.rptr;
      prev_raddr = bus.raddr;
    end
    chk("wrap_pops",        32'(pops),        40);
    chk("wrap_raddr_wraps", 32'(raddr_wraps), 2);
    chk("wrap_rptr_wraps",  32'(rptr_wraps),  1);

    // Simultaneous pop and write-pointer advance at level 1 (rbin=8, wb=9)
    bus.rinc = 1'b0;
    tick();
    chk("simul_pre_rlevel", 32'(bus.rlevel), 1);
    chk("simul_pre_rempty", 32'(bus.rempty), 0);
    bus.rinc = 1'b1;
    bus.rq2_wptr = g(5'd10);
    tick();
    chk("simul_rempty", 32'(bus.rempty), 0);
    chk("simul_rlevel", 32'(bus.rlevel), 1);
    chk("simul_raddr",  32'(bus.raddr),  9);

    // Mid-operation reset at level 7 (rbin=9 -> wb=17)
    bus.rinc = 1'b0;
    bus.rq2_wptr = g(5'd17);
    tick();
    chk("mid_pre_rlevel", 32'(bus.rlevel), 8);
    bus.rinc = 1'b1;
    tick();
    chk("mid_rlevel7", 32'(bus.rlevel), 7);
    chk("mid_raddr",   32'(bus.raddr),  10);
    rrst_n = 1'b0;
    tick();
    chk_reset_vals("midrst");

    // Resume after release with three words visible
    rrst_n = 1'b1;
    bus.rq2_wptr = g(5'd3);
    tick();
    chk("resume0_raddr",  32'(bus.raddr),  0);
    chk("resume0_rlevel", 32'(bus.rlevel), 3);
    chk("resume0_rempty", 32'(bus.rempty), 0);
    tick();
    chk("resume1_raddr",   32'(bus.raddr),   1);
    chk("resume1_rlevel",  32'(bus.rlevel),  2);
    chk("resume1_raempty", 32'(bus.raempty), 1);
    tick();
    chk("resume2_raddr",  32'(bus.raddr),  2);
    chk("resume2_rlevel", 32'(bus.rlevel), 1);
    tick();
    chk("resume3_raddr",  32'(bus.raddr),  3);
    chk("resume3_rempty", 32'(bus.rempty), 1);
    chk("resume3_rptr",   32'(bus.rptr),   32'b00010);
    bus.rinc = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
